// File: rtl/hilo_if.sv
// hilo_if: signal bundle between hilo_unit, the control unit and the
// multiplier/divider pair.
//   requests  : op_mult, op_div, mthi, mtlo, mfhi, mflo
//   operands  : rs_data, rt_data (in), op_a, op_b (registered, out)
//   unit side : mult_hi/lo/done, div_hi/lo/done/zero (in), mult_start, div_start (out)
//   arch regs : hi, lo, rd_data, rd_valid, stall, op_error (out)
// Modport slave is the HI/LO unit; master is everything around it.
interface hilo_if;
  logic        op_mult;
  logic        op_div;
  logic        mthi;
  logic        mtlo;
  logic        mfhi;
  logic        mflo;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;
  logic        mult_done;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  logic        div_done;
  logic        div_zero;
  logic        mult_start;
  logic        div_start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        stall;
  logic        op_error;

  modport slave (
    input  op_mult, op_div, mthi, mtlo, mfhi, mflo,
    input  rs_data, rt_data,
    input  mult_hi, mult_lo, mult_done,
    input  div_hi, div_lo, div_done, div_zero,
    output mult_start, div_start, op_a, op_b,
    output hi, lo, rd_data, rd_valid, stall, op_error
  );

  modport master (
    output op_mult, op_div, mthi, mtlo, mfhi, mflo,
    output rs_data, rt_data,
    output mult_hi, mult_lo, mult_done,
    output div_hi, div_lo, div_done, div_zero,
    input  mult_start, div_start, op_a, op_b,
    input  hi, lo, rd_data, rd_valid, stall, op_error
  );
endinterface

// File: rtl/hilo_unit.sv
// hilo_unit: sequences MULT/DIV through the external multiplier and divider
// and owns the architectural HI/LO registers. Serves MTHI/MTLO/MFHI/MFLO and
// stalls the control unit while an operation is in flight.
// Ports: clock, reset (synchronous, active-high), bus (hilo_if.slave).
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | accepting requests; HI/LO moves and reads happen here
// MULT_ISSUE | mult_start is high; done still shows the previous op
// MULT_WAIT  | waiting for mult_done or timeout
// DIV_ISSUE  | div_start is high; done still shows the previous op
// DIV_WAIT   | waiting for div_done (div_zero checked) or timeout
module hilo_unit #(
  parameter int TIMEOUT = 63
) (
  input logic   clock,
  input logic   reset,
  hilo_if.slave bus
);
  localparam int CntWidth = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    MULT_ISSUE,
    MULT_WAIT,
    DIV_ISSUE,
    DIV_WAIT
  } state_t;

  state_t              stateQ, stateD;
  logic [CntWidth-1:0] waitCnt;
  logic                timeoutHit;
  logic                anyReq;
  logic acceptMult, acceptDiv, acceptMthi, acceptMtlo, acceptMfhi, acceptMflo;
  logic captureMult, captureDiv, raiseError, cntClear, cntInc;
  logic        multStartQ, divStartQ, rdValidQ, opErrorQ;
  logic [31:0] opAQ, opBQ, hiQ, loQ, rdDataQ;

  assign timeoutHit = (waitCnt == CntWidth'(TIMEOUT));
  assign anyReq     = bus.op_mult | bus.op_div | bus.mthi | bus.mtlo | bus.mfhi | bus.mflo;

  always_ff @(posedge clock) begin
    if (reset) stateQ <= IDLE;
    else       stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE: begin
        if (bus.op_mult)     stateD = MULT_ISSUE;
        else if (bus.op_div) stateD = DIV_ISSUE;
      end
      MULT_ISSUE: stateD = MULT_WAIT;
      DIV_ISSUE:  stateD = DIV_WAIT;
      MULT_WAIT:  if (bus.mult_done || timeoutHit) stateD = IDLE;
      DIV_WAIT:   if (bus.div_done || timeoutHit) stateD = IDLE;
      default:    stateD = IDLE;
    endcase
  end

  // Done levels are only looked at in the WAIT states, so a level left over
  // from the previous operation cannot be mistaken for completion.
  always_comb begin
    acceptMult  = 1'b0;
    acceptDiv   = 1'b0;
    acceptMthi  = 1'b0;
    acceptMtlo  = 1'b0;
    acceptMfhi  = 1'b0;
    acceptMflo  = 1'b0;
    captureMult = 1'b0;
    captureDiv  = 1'b0;
    raiseError  = 1'b0;
    cntClear    = 1'b0;
    cntInc      = 1'b0;
    case (stateQ)
      IDLE: begin
        if (bus.op_mult)      acceptMult = 1'b1;
        else if (bus.op_div)  acceptDiv  = 1'b1;
        else if (bus.mthi)    acceptMthi = 1'b1;
        else if (bus.mtlo)    acceptMtlo = 1'b1;
        else if (bus.mfhi)    acceptMfhi = 1'b1;
        else if (bus.mflo)    acceptMflo = 1'b1;
      end
      MULT_ISSUE, DIV_ISSUE: cntClear = 1'b1;
      MULT_WAIT: begin
        if (bus.mult_done)    captureMult = 1'b1;
        else if (timeoutHit)  raiseError  = 1'b1;
        else                  cntInc      = 1'b1;
      end
      DIV_WAIT: begin
        if (bus.div_done) begin
          if (bus.div_zero)   raiseError = 1'b1;
          else                captureDiv = 1'b1;
        end
        else if (timeoutHit)  raiseError = 1'b1;
        else                  cntInc     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      multStartQ <= 1'b0;
      divStartQ  <= 1'b0;
      opAQ       <= '0;
      opBQ       <= '0;
      hiQ        <= '0;
      loQ        <= '0;
      rdDataQ    <= '0;
      rdValidQ   <= 1'b0;
      opErrorQ   <= 1'b0;
      waitCnt    <= '0;
    end else begin
      multStartQ <= acceptMult;
      divStartQ  <= acceptDiv;
      if (acceptMult || acceptDiv) begin
        opAQ <= bus.rs_data;
        opBQ <= bus.rt_data;
      end
      if (captureMult) begin
        hiQ <= bus.mult_hi;
        loQ <= bus.mult_lo;
      end else if (captureDiv) begin
        hiQ <= bus.div_hi;
        loQ <= bus.div_lo;
      end else begin
        if (acceptMthi) hiQ <= bus.rs_data;
        if (acceptMtlo) loQ <= bus.rs_data;
      end
      if (acceptMfhi)      rdDataQ <= hiQ;
      else if (acceptMflo) rdDataQ <= loQ;
      rdValidQ <= acceptMfhi | acceptMflo;
      opErrorQ <= raiseError;
      if (cntClear)    waitCnt <= '0;
      else if (cntInc) waitCnt <= waitCnt + 1'b1;
    end
  end

  assign bus.mult_start = multStartQ;
  assign bus.div_start  = divStartQ;
  assign bus.op_a       = opAQ;
  assign bus.op_b       = opBQ;
  assign bus.hi         = hiQ;
  assign bus.lo         = loQ;
  assign bus.rd_data    = rdDataQ;
  assign bus.rd_valid   = rdValidQ;
  assign bus.op_error   = opErrorQ;
  assign bus.stall      = (stateQ != IDLE) && anyReq;
endmodule

// File: tb/tb_hilo_unit.sv
module tb_hilo_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  hilo_if bus();
  hilo_unit #(.TIMEOUT(63)) dut (.clock(clock), .reset(reset), .bus(bus));

  int nTests = 0;
  int nFail = 0;
  int multStarts = 0;
  int divStarts = 0;
  int errCycles = 0;
  logic [63:0] expQ[$];
  logic [31:0] rdQ[$];
  logic [31:0] shHi = '0;
  logic [31:0] shLo = '0;

  int multLat = 32;
  int divLat = 10;
  bit multHang = 1'b0;
  int mCnt, dCnt;
  bit mBusy, dBusy;
  logic [31:0] mA, mB, dA, dB;

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return 64'(p);
  endfunction

  // Multiplier model: done is a level that drops on start; results are junk until done.
  always @(posedge clock) begin
    if (reset) begin
      bus.mult_done <= 1'b0; bus.mult_hi <= '0; bus.mult_lo <= '0; mBusy <= 1'b0; mCnt <= 0;
    end else if (bus.mult_start) begin
      bus.mult_done <= 1'b0; bus.mult_hi <= 32'hDEADBEEF; bus.mult_lo <= 32'hDEADBEEF;
      mA <= bus.op_a; mB <= bus.op_b; mCnt <= multLat; mBusy <= 1'b1;
    end else if (mBusy && !multHang) begin
      if (mCnt <= 1) begin
        {bus.mult_hi, bus.mult_lo} <= smul(mA, mB);
        bus.mult_done <= 1'b1; mBusy <= 1'b0;
      end else mCnt <= mCnt - 1;
    end
  end

  // Divider model: HI = remainder, LO = quotient, div_zero flags rt == 0.
  always @(posedge clock) begin
    if (reset) begin
      bus.div_done <= 1'b0; bus.div_zero <= 1'b0; bus.div_hi <= '0; bus.div_lo <= '0;
      dBusy <= 1'b0; dCnt <= 0;
    end else if (bus.div_start) begin
      bus.div_done <= 1'b0; bus.div_zero <= 1'b0; bus.div_hi <= 32'hBAD0BAD0; bus.div_lo <= 32'hBAD0BAD0;
      dA <= bus.op_a; dB <= bus.op_b; dCnt <= divLat; dBusy <= 1'b1;
    end else if (dBusy) begin
      if (dCnt <= 1) begin
        if (dB == 0) bus.div_zero <= 1'b1;
        else begin bus.div_hi <= dA % dB; bus.div_lo <= dA / dB; end
        bus.div_done <= 1'b1; dBusy <= 1'b0;
      end else dCnt <= dCnt - 1;
    end
  end

  always @(posedge clock) begin
    if (bus.mult_start) multStarts++;
    if (bus.div_start) divStarts++;
    if (bus.op_error) errCycles++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input bit isDiv, input logic [31:0] rs, input logic [31:0] rt);
    bus.rs_data = rs;
    bus.rt_data = rt;
    if (isDiv) bus.op_div = 1'b1;
    else bus.op_mult = 1'b1;
    tick();
    bus.op_mult = 1'b0;
    bus.op_div = 1'b0;
  endtask

  task automatic wait_done(input bit isDiv, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (isDiv ? bus.div_done : bus.mult_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    tick(); tick(); tick();
    nTests++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin nFail++; $display("FAIL reset_hilo: got %h/%h expected 0/0", bus.hi, bus.lo); end
    nTests++; if (bus.rd_data !== 32'h0 || bus.rd_valid !== 1'b0) begin nFail++; $display("FAIL reset_rd: got %h/%b expected 0/0", bus.rd_data, bus.rd_valid); end
    nTests++; if (bus.op_a !== 32'h0 || bus.op_b !== 32'h0) begin nFail++; $display("FAIL reset_ops: got %h/%h expected 0/0", bus.op_a, bus.op_b); end
    nTests++; if ({bus.mult_start, bus.div_start, bus.op_error, bus.stall} !== 4'b0) begin nFail++; $display("FAIL reset_ctrl: got %b expected 0000", {bus.mult_start, bus.div_start, bus.op_error, bus.stall}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mult();
    bit ok;
    logic [63:0] want;
    logic [31:0] rdWant;
    int starts0 = multStarts;
    issue(1'b0, 32'd7, 32'hFFFFFFFD);
    expQ.push_back(64'hFFFFFFFF_FFFFFFEB);
    nTests++; if (bus.mult_start !== 1'b1) begin nFail++; $display("FAIL mult_start_pulse: got %b expected 1", bus.mult_start); end
    nTests++; if (bus.op_a !== 32'd7 || bus.op_b !== 32'hFFFFFFFD) begin nFail++; $display("FAIL mult_operands: got %h/%h expected 7/fffffffd", bus.op_a, bus.op_b); end
    tick();
    nTests++; if (bus.mult_start !== 1'b0) begin nFail++; $display("FAIL mult_start_width: got %b expected 0", bus.mult_start); end
    wait_done(1'b0, 200, ok);
    nTests++; if (!ok) begin nFail++; $display("FAIL mult_wait: got no done expected done within 200 cycles"); end
    tick();
    want = expQ.pop_front();
    nTests++; if (bus.hi !== want[63:32]) begin nFail++; $display("FAIL mult_hi: got %h expected %h", bus.hi, want[63:32]); end
    nTests++; if (bus.lo !== want[31:0]) begin nFail++; $display("FAIL mult_lo: got %h expected %h", bus.lo, want[31:0]); end
    shHi = want[63:32]; shLo = want[31:0];
    nTests++; if (multStarts - starts0 != 1) begin nFail++; $display("FAIL mult_start_count: got %0d expected 1", multStarts - starts0); end
    bus.mfhi = 1'b1;
    #1;
    nTests++; if (bus.stall !== 1'b0) begin nFail++; $display("FAIL mult_idle_stall: got %b expected 0", bus.stall); end
    rdQ.push_back(shHi);
    tick();
    bus.mfhi = 1'b0;
    rdWant = rdQ.pop_front();
    nTests++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== rdWant) begin nFail++; $display("FAIL mfhi_read: got %h valid %b expected %h valid 1", bus.rd_data, bus.rd_valid, rdWant); end
    tick();
    nTests++; if (bus.rd_valid !== 1'b0) begin nFail++; $display("FAIL mfhi_valid_width: got %b expected 0", bus.rd_valid); end
  endtask

  task automatic test_mfhi_stall();
    bit ok;
    logic [63:0] want;
    logic [31:0] rdWant;
    multLat = 8;
    issue(1'b0, 32'h40000000, 32'h10);
    expQ.push_back(64'h00000004_00000000);
    bus.mfhi = 1'b1;
    #1;
    nTests++; if (bus.stall !== 1'b1) begin nFail++; $display("FAIL stall_issue: got %b expected 1", bus.stall); end
    tick();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      nTests++; if (bus.stall !== 1'b1 || bus.rd_valid !== 1'b0) begin nFail++; $display("FAIL stall_wait cycle %0d: got stall %b valid %b expected 1/0", i, bus.stall, bus.rd_valid); end
      if (bus.mult_done) begin ok = 1'b1; break; end
      tick();
    end
    nTests++; if (!ok) begin nFail++; $display("FAIL stall_done_wait: got no done expected done within 100 cycles"); end
    tick();
    want = expQ.pop_front();
    shHi = want[63:32]; shLo = want[31:0];
    nTests++; if (bus.stall !== 1'b0 || bus.rd_valid !== 1'b0) begin nFail++; $display("FAIL stall_release: got stall %b valid %b expected 0/0", bus.stall, bus.rd_valid); end
    rdQ.push_back(shHi);
    tick();
    bus.mfhi = 1'b0;
    rdWant = rdQ.pop_front();
    nTests++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== rdWant) begin nFail++; $display("FAIL stalled_mfhi_read: got %h valid %b expected %h valid 1", bus.rd_data, bus.rd_valid, rdWant); end
    tick();
    nTests++; if (bus.rd_valid !== 1'b0) begin nFail++; $display("FAIL stalled_mfhi_single: got %b expected 0", bus.rd_valid); end
  endtask

  task automatic test_stale_done();
    bit ok;
    logic [63:0] want;
    int starts0 = multStarts;
    multLat = 5;
    issue(1'b0, 32'd5, 32'd6);
    expQ.push_back(64'd30);
    tick();
    nTests++; if (bus.hi !== shHi || bus.lo !== shLo) begin nFail++; $display("FAIL stale_no_capture: got %h/%h expected %h/%h", bus.hi, bus.lo, shHi, shLo); end
    bus.mflo = 1'b1;
    #1;
    nTests++; if (bus.stall !== 1'b1) begin nFail++; $display("FAIL stale_still_waiting: got stall %b expected 1", bus.stall); end
    bus.mflo = 1'b0;
    wait_done(1'b0, 100, ok);
    nTests++; if (!ok) begin nFail++; $display("FAIL stale_wait: got no done expected done within 100 cycles"); end
    tick();
    want = expQ.pop_front();
    nTests++; if (bus.hi !== want[63:32] || bus.lo !== want[31:0]) begin nFail++; $display("FAIL stale_capture: got %h/%h expected %h/%h", bus.hi, bus.lo, want[63:32], want[31:0]); end
    shHi = want[63:32]; shLo = want[31:0];
    nTests++; if (multStarts - starts0 != 1) begin nFail++; $display("FAIL stale_start_count: got %0d expected 1", multStarts - starts0); end
  endtask

  task automatic test_div();
    bit ok;
    logic [63:0] want;
    int err0 = errCycles;
    int starts0 = divStarts;
    divLat = 10;
    issue(1'b1, 32'd100, 32'd7);
    expQ.push_back({32'd2, 32'd14});
    nTests++; if (bus.div_start !== 1'b1 || bus.mult_start !== 1'b0) begin nFail++; $display("FAIL div_start_pulse: got div %b mult %b expected 1/0", bus.div_start, bus.mult_start); end
    tick();
    wait_done(1'b1, 100, ok);
    nTests++; if (!ok) begin nFail++; $display("FAIL div_wait: got no done expected done within 100 cycles"); end
    tick();
    want = expQ.pop_front();
    nTests++; if (bus.hi !== want[63:32] || bus.lo !== want[31:0]) begin nFail++; $display("FAIL div_result: got %h/%h expected %h/%h", bus.hi, bus.lo, want[63:32], want[31:0]); end
    shHi = want[63:32]; shLo = want[31:0];
    tick();
    nTests++; if (errCycles - err0 != 0 || bus.op_error !== 1'b0) begin nFail++; $display("FAIL div_no_error: got %0d error cycles expected 0", errCycles - err0); end
    nTests++; if (divStarts - starts0 != 1) begin nFail++; $display("FAIL div_start_count: got %0d expected 1", divStarts - starts0); end
  endtask

  task automatic test_div_zero();
    bit ok;
    logic [63:0] want;
    bus.rs_data = 32'h11; bus.mthi = 1'b1;
    tick();
    bus.mthi = 1'b0; bus.rs_data = 32'h22; bus.mtlo = 1'b1;
    nTests++; if (bus.hi !== 32'h11 || bus.rd_valid !== 1'b0) begin nFail++; $display("FAIL mthi: got %h valid %b expected 11 valid 0", bus.hi, bus.rd_valid); end
    tick();
    bus.mtlo = 1'b0;
    nTests++; if (bus.lo !== 32'h22 || bus.hi !== 32'h11) begin nFail++; $display("FAIL mtlo: got %h/%h expected 11/22", bus.hi, bus.lo); end
    shHi = 32'h11; shLo = 32'h22;
    issue(1'b1, 32'h99, 32'h0);
    expQ.push_back({shHi, shLo});
    tick();
    wait_done(1'b1, 100, ok);
    nTests++; if (!ok) begin nFail++; $display("FAIL divzero_wait: got no done expected done within 100 cycles"); end
    tick();
    want = expQ.pop_front();
    nTests++; if (bus.op_error !== 1'b1) begin nFail++; $display("FAIL divzero_error: got %b expected 1", bus.op_error); end
    nTests++; if (bus.hi !== want[63:32] || bus.lo !== want[31:0]) begin nFail++; $display("FAIL divzero_hilo: got %h/%h expected %h/%h", bus.hi, bus.lo, want[63:32], want[31:0]); end
    tick();
    nTests++; if (bus.op_error !== 1'b0) begin nFail++; $display("FAIL divzero_error_width: got %b expected 0", bus.op_error); end
  endtask

  task automatic test_timeout();
    logic [63:0] want;
    int err0 = errCycles;
    multHang = 1'b1;
    issue(1'b0, 32'd3, 32'd3);
    expQ.push_back({shHi, shLo});
    tick();
    for (int i = 0; i < 63; i++) tick();
    nTests++; if (bus.op_error !== 1'b0 || errCycles - err0 != 0) begin nFail++; $display("FAIL timeout_early: got error %b after 63 wait cycles expected 0", bus.op_error); end
    tick();
    nTests++; if (bus.op_error !== 1'b1) begin nFail++; $display("FAIL timeout_error: got %b after 64 wait cycles expected 1", bus.op_error); end
    want = expQ.pop_front();
    nTests++; if (bus.hi !== want[63:32] || bus.lo !== want[31:0]) begin nFail++; $display("FAIL timeout_hilo: got %h/%h expected %h/%h", bus.hi, bus.lo, want[63:32], want[31:0]); end
    tick();
    nTests++; if (bus.op_error !== 1'b0) begin nFail++; $display("FAIL timeout_error_width: got %b expected 0", bus.op_error); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rdWant;
    divLat = 30;
    issue(1'b1, 32'd50, 32'd5);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    nTests++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin nFail++; $display("FAIL midreset_hilo: got %h/%h expected 0/0", bus.hi, bus.lo); end
    nTests++; if ({bus.mult_start, bus.div_start, bus.op_error} !== 3'b0) begin nFail++; $display("FAIL midreset_pulses: got %b expected 000", {bus.mult_start, bus.div_start, bus.op_error}); end
    shHi = '0; shLo = '0;
    bus.mflo = 1'b1;
    #1;
    nTests++; if (bus.stall !== 1'b0) begin nFail++; $display("FAIL midreset_idle: got stall %b expected 0", bus.stall); end
    reset = 1'b0;
    multHang = 1'b0;
    rdQ.push_back(shLo);
    tick();
    bus.mflo = 1'b0;
    rdWant = rdQ.pop_front();
    nTests++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== rdWant) begin nFail++; $display("FAIL midreset_mflo: got %h valid %b expected %h valid 1", bus.rd_data, bus.rd_valid, rdWant); end
    tick();
  endtask

  task automatic test_priority();
    logic [31:0] rdWant;
    bus.rs_data = 32'hA5A5A5A5; bus.mthi = 1'b1; bus.mtlo = 1'b1;
    tick();
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    nTests++; if (bus.hi !== 32'hA5A5A5A5 || bus.lo !== shLo) begin nFail++; $display("FAIL prio_mthi: got %h/%h expected a5a5a5a5/%h", bus.hi, bus.lo, shLo); end
    shHi = 32'hA5A5A5A5;
    bus.mfhi = 1'b1; bus.mflo = 1'b1;
    rdQ.push_back(shHi);
    tick();
    bus.mfhi = 1'b0; bus.mflo = 1'b0;
    rdWant = rdQ.pop_front();
    nTests++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== rdWant) begin nFail++; $display("FAIL prio_mfhi: got %h valid %b expected %h valid 1", bus.rd_data, bus.rd_valid, rdWant); end
    tick();
  endtask

  initial begin
    bus.op_mult = 1'b0; bus.op_div = 1'b0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.mfhi = 1'b0; bus.mflo = 1'b0;
    bus.rs_data = '0; bus.rt_data = '0;
    test_reset();
    test_mult();
    test_mfhi_stall();
    test_stale_done();
    test_div();
    test_div_zero();
    test_timeout();
    test_reset_mid();
    test_priority();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/hilo_unit.md
# hilo_unit

Sequences MULT/DIV operations for the multicycle datapath and owns the architectural HI/LO registers. It issues start pulses to the Booth multiplier and the divider, and captures their 32-bit results when each signals completion. It serves MFHI/MFLO/MTHI/MTLO and stalls the control unit while a result is pending. It sits directly downstream of the multiplier and divider, between them and the register-file write path.

## Interface
- TIMEOUT, 63: cycles allowed in a WAIT state before the operation is abandoned.
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- op_mult / op_div  in  1  request a multiply / divide of rs_data by rt_data.
- mthi / mtlo  in  1  write rs_data to HI / LO.
- mfhi / mflo  in  1  read HI / LO onto rd_data.
- rs_data, rt_data  in  32  operands.
- mult_hi, mult_lo  in  32  multiplier result.
- mult_done  in  1  multiplier completion. This is a level: it stays high until the next start.
- div_hi (remainder), div_lo (quotient)  in  32  divider result.
- div_done, div_zero  in  1  divider completion level; divide-by-zero flag.
- mult_start, div_start  out  1  one-cycle start pulse to each unit.
- op_a, op_b  out  32  registered operands to both units.
- hi, lo  out  32  architectural HI/LO.
- rd_data  out  32  registered read data.
- rd_valid  out  1  one-cycle pulse when rd_data is new.
- stall  out  1  control unit must hold the current instruction.
- op_error  out  1  one-cycle pulse on divide-by-zero or timeout.

## Operation
- States:
  - IDLE
  - MULT_ISSUE, MULT_WAIT
  - DIV_ISSUE, DIV_WAIT
- Reset values: state IDLE. All of the following are 0: hi, lo, rd_data, rd_valid, mult_start, div_start, op_a, op_b, op_error, timeout counter.
- Request priority in IDLE, if several requests are high together: op_mult > op_div > mthi > mtlo > mfhi > mflo. Lower-priority requests are dropped and not stalled; the control unit guarantees one-hot requests.
- IDLE + op_mult:
  - Latch op_a = rs_data, op_b = rt_data.
  - Pulse mult_start; go to MULT_ISSUE.
  - op_div is identical, using div_start and DIV_ISSUE.
- MULT_ISSUE / DIV_ISSUE last exactly one cycle. Done inputs are ignored here, because they still show the previous operation's level. Next state is the matching WAIT state; the counter is cleared.
- MULT_WAIT:
  - On mult_done = 1: hi <= mult_hi, lo <= mult_lo; go to IDLE.
  - Otherwise the counter increments.
- DIV_WAIT:
  - On div_done = 1 with div_zero = 0: hi <= div_hi, lo <= div_lo; go to IDLE.
  - On div_done = 1 with div_zero = 1: HI/LO unchanged; pulse op_error; go to IDLE.
- Timeout: in either WAIT state, when the counter reaches TIMEOUT without done, go to IDLE, pulse op_error, leave HI/LO unchanged.
- mthi / mtlo in IDLE: the register updates at the edge; no rd_valid.
- mfhi / mflo in IDLE: rd_data <= hi (or lo) at the edge; rd_valid pulses for one cycle.
- stall is combinational: 1 whenever state != IDLE and any of op_mult, op_div, mthi, mtlo, mfhi, mflo is high. Stalled requests are not consumed; the control unit holds them.
- Capture in the same cycle as a stalled mfhi:
  - stall is still 1 in that cycle.
  - The next cycle is IDLE, and the read returns the new value.
- Arithmetic: the block does no computation; results pass through bit-exact. The divider follows the convention HI = remainder, LO = quotient.

## Timing
- Start pulse: asserted in the cycle after the request edge and held for exactly one cycle.
- Completion: HI/LO update at the first edge at which mult_done or div_done is sampled high in a WAIT state.
- Multiply: about 34 cycles from request to HI/LO valid with the 32-iteration multiplier.
- Read: rd_data and rd_valid are valid 1 cycle after an accepted mfhi/mflo.
- Reset mid-operation:
  - Immediate return to IDLE; start pulses are cancelled and HI/LO are zeroed.
  - The multiplier and divider share the reset.
  - A done level arriving after reset is ignored, because done is only sampled in a WAIT state.
- op_error: a single-cycle pulse, coincident with the return to IDLE.

## Test plan
- Multiply: rs = 7, rt = 0xFFFFFFFD (-3), model multiplier.
  - Required: hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; mult_start pulses once; stall is 0 once back in IDLE.
- Divide: rs = 100, rt = 7.
  - Required: hi = 2, lo = 14, op_error = 0.
- Divide by zero: prior hi = 0x11, lo = 0x22; divide with rt = 0 (div_zero = 1).
  - Required: op_error pulses; hi/lo remain 0x11/0x22.
- mfhi during MULT_WAIT:
  - Required: stall stays 1 every cycle until capture.
  - Required: the next cycle gives rd_data = new hi with a single rd_valid.
- Stale done: mult_done is held high from a previous op when a new op_mult issues.
  - Required: no capture in MULT_ISSUE.
  - Required: capture only after the model drops then raises done.
- Timeout and reset:
  - Model never asserts done: op_error fires after TIMEOUT + 1 cycles in WAIT, with HI/LO unchanged.
  - Reset asserted mid-WAIT: state IDLE and hi = lo = 0 at the next edge.
